// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, the NOP word and the
// primary opcode values decoded from instr[31:26].
package cpu_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Redirect targets are forced to a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request, valid/ready output
// towards the decoder, and redirect handling that drops in-flight responses.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              imem_req_o,
   output logic [31:0]       imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [31:0]       imem_rdata_i,
   output logic [31:0]       instr_o,
   output logic [31:0]       pc_o,
   output logic [31:0]       pc_plus4_o,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   output logic              align_err_o,
   output logic [CNT_W-1:0]  fetch_cnt_o,
   output fetch_state_t      dbg_state_o
);

   // Handshake: instr_o/pc_o transfer on a cycle where instr_valid_o and
   // instr_ready_i are both high; while valid is high and ready is low the
   // outputs do not change. Memory side: imem_addr_o holds while imem_req_o is
   // high until the cycle imem_ack_i is seen (ack may come in the first cycle).

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  pend_pc;
   logic [31:0]  tgt;
   logic         handshake;

   assign tgt       = word_align(redirect_pc_i);
   assign handshake = instr_valid_o & instr_ready_i;

   // During S_FLUSH fetch_pc still holds the in-flight (stale) address.
   assign imem_req_o  = rst_i & ((state == S_FETCH) | (state == S_FLUSH));
   assign imem_addr_o = fetch_pc;
   assign pc_plus4_o  = pc_o + 32'd4;
   assign dbg_state_o = state;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= S_FETCH;
         fetch_pc      <= RESET_PC;
         pend_pc       <= 32'h0;
         instr_o       <= INSTR_NOP;
         pc_o          <= RESET_PC;
         instr_valid_o <= 1'b0;
         align_err_o   <= 1'b0;
         fetch_cnt_o   <= '0;
      end else begin
         if (redirect_i && (redirect_pc_i[1:0] != 2'b00))
            align_err_o <= 1'b1;

         case (state)
            S_FETCH: begin
               if (redirect_i) begin
                  if (imem_ack_i) begin
                     fetch_pc <= tgt;
                  end else begin
                     pend_pc <= tgt;
                     state   <= S_FLUSH;
                  end
               end else if (imem_ack_i) begin
                  instr_o       <= imem_rdata_i;
                  pc_o          <= fetch_pc;
                  instr_valid_o <= 1'b1;
                  fetch_pc      <= fetch_pc + 32'd4;
                  state         <= S_VALID;
               end
            end
            S_VALID: begin
               if (handshake)
                  fetch_cnt_o <= fetch_cnt_o + CNT_ONE;
               if (redirect_i) begin
                  instr_valid_o <= 1'b0;
                  fetch_pc      <= tgt;
                  state         <= S_FETCH;
               end else if (handshake) begin
                  instr_valid_o <= 1'b0;
                  state         <= S_FETCH;
               end
            end
            S_FLUSH: begin
               // The response for the abandoned address is dropped here.
               if (imem_ack_i) begin
                  fetch_pc <= redirect_i ? tgt : pend_pc;
                  state    <= S_FETCH;
               end else if (redirect_i) begin
                  pend_pc <= tgt;
               end
            end
            default: begin
               state         <= S_FETCH;
               instr_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
